// File: rtl/rsa_keygen_ctrl_if.sv
// Handshake and data bundle between the RSA key-generation controller, its
// request source, the modular inverter and the key consumer.
interface rsa_keygen_ctrl_if #(
    parameter int WIDTH = 32
);
    // request side
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_p;
    logic [WIDTH-1:0]     req_q;

    // inverter side
    logic                 inv_start;
    logic [WIDTH-1:0]     inv_p;
    logic [WIDTH-1:0]     inv_q;
    logic                 inv_finish;
    logic [2*WIDTH-1:0]   inv_e;
    logic [2*WIDTH-1:0]   inv_d;

    // key/result side
    logic                 key_valid;
    logic                 key_ready;
    logic [2*WIDTH-1:0]   key_n;
    logic [2*WIDTH-1:0]   key_e;
    logic [2*WIDTH-1:0]   key_d;
    logic                 key_err;
    logic [23:0]          key_cycles;
    logic                 busy;

    modport slave (
        input  req_valid, req_p, req_q,
        input  inv_finish, inv_e, inv_d,
        input  key_ready,
        output req_ready,
        output inv_start, inv_p, inv_q,
        output key_valid, key_n, key_e, key_d, key_err, key_cycles,
        output busy
    );

    modport master (
        output req_valid, req_p, req_q,
        output inv_finish, inv_e, inv_d,
        output key_ready,
        input  req_ready,
        input  inv_start, inv_p, inv_q,
        input  key_valid, key_n, key_e, key_d, key_err, key_cycles,
        input  busy
    );
endinterface

// File: rtl/rsa_keygen_ctrl.sv
// RSA key-generation sequencer: validates the prime pair, kicks the external
// inverter, waits for it with a timeout and presents n/e/d to the consumer.
module rsa_keygen_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
) (
    input logic              clk,
    input logic              reset,
    rsa_keygen_ctrl_if.slave bus
);

    localparam int KW = 2 * WIDTH;
    // At TIMEOUT = 2^24 the reported cycle count wraps to 0 in the 24-bit field.
    localparam logic [23:0] CNT_LAST    = 24'(TIMEOUT - 1);
    localparam logic [23:0] CNT_TIMEOUT = 24'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  p_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [23:0]       cnt;

    logic [KW-1:0]     key_n;
    logic [KW-1:0]     key_e;
    logic [KW-1:0]     key_d;
    logic              key_err;
    logic [23:0]       key_cycles;

    logic              accept;
    logic              reject;
    logic              capture;
    logic              expire;

    function automatic logic operands_ok(input logic [WIDTH-1:0] p,
                                         input logic [WIDTH-1:0] q);
        return (p >= WIDTH'(3)) && (q >= WIDTH'(3)) && (p != q);
    endfunction

    function automatic logic [KW-1:0] modulus(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q);
        return KW'(p) * KW'(q);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (operands_ok(bus.req_p, bus.req_q)) begin
                        state_next = START;
                    end else begin
                        reject     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                // The first WAIT cycle may still see a finish left over from
                // the previous run, so only later cycles count; finish beats
                // a coincident timeout.
                if ((cnt != 24'd0) && bus.inv_finish) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    expire     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.key_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= '0;
            q_reg <= '0;
        end else if (accept) begin
            p_reg <= bus.req_p;
            q_reg <= bus.req_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == START) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 24'd1;
        end
    end

    // Result registers: written only on a capture, a reject or a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_n      <= '0;
            key_e      <= '0;
            key_d      <= '0;
            key_err    <= 1'b0;
            key_cycles <= '0;
        end else if (capture) begin
            key_n      <= modulus(p_reg, q_reg);
            key_e      <= bus.inv_e;
            key_d      <= bus.inv_d;
            key_err    <= 1'b0;
            key_cycles <= cnt + 24'd1;
        end else if (expire) begin
            key_n      <= '0;
            key_e      <= '0;
            key_d      <= '0;
            key_err    <= 1'b1;
            key_cycles <= CNT_TIMEOUT;
        end else if (reject) begin
            key_n      <= '0;
            key_e      <= '0;
            key_d      <= '0;
            key_err    <= 1'b1;
            key_cycles <= '0;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.inv_start  = (state == START);
    assign bus.key_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);

    assign bus.inv_p      = p_reg;
    assign bus.inv_q      = q_reg;

    assign bus.key_n      = key_n;
    assign bus.key_e      = key_e;
    assign bus.key_d      = key_d;
    assign bus.key_err    = key_err;
    assign bus.key_cycles = key_cycles;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Bench for rsa_keygen_ctrl: stub inverter, directed and random requests,
// per-run expectations from a transaction-level model, per-cycle checks.
module tb_rsa_keygen_ctrl;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rsa_keygen_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rsa_keygen_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one request.
    typedef struct {
        logic [31:0] p, q;
        logic [63:0] n, e, d;
        logic        err;
        int          cycles;
        bit          bad;
    } exp_t;

    exp_t expq[$];

    function automatic exp_t model(input logic [31:0] p, q, input logic [63:0] e, d,
                                   input int dly, input bit never);
        exp_t r;
        r.p = p; r.q = q;
        r.n = 0; r.e = 0; r.d = 0; r.err = 1; r.cycles = 0; r.bad = 0;
        if (p < 3 || q < 3 || p == q) begin
            r.bad = 1;
        end else if (!never && dly <= TIMEOUT) begin
            r.n = 64'(p) * 64'(q);
            r.e = e; r.d = d; r.err = 0; r.cycles = dly;
        end else begin
            r.cycles = TIMEOUT;
        end
        return r;
    endfunction

    function automatic exp_t lit(input logic [31:0] p, q, input logic [63:0] n, e, d,
                                 input logic err, input int cycles, input bit bad);
        exp_t r;
        r.p = p; r.q = q; r.n = n; r.e = e; r.d = d;
        r.err = err; r.cycles = cycles; r.bad = bad;
        return r;
    endfunction

    // Stub inverter: synchronously restarted by inv_start, finishes dly cycles
    // after the start pulse; optionally shows a stale finish until one WAIT cycle in.
    logic [63:0] stub_e = 0, stub_d = 0;
    int          stub_dly = 10;
    bit          stub_never = 0, stub_stale = 0;
    int          sc = 0;
    bit          started = 0;

    always @(posedge clk) begin
        if (bus.inv_start) begin
            sc      <= 0;
            started <= 1;
        end else begin
            if (sc < 100000) sc <= sc + 1;
            if (bus.req_valid && bus.req_ready) started <= 0;
        end
    end

    assign bus.inv_finish = (stub_stale && (!started || sc == 0)) ||
                            (started && !stub_never && sc >= stub_dly - 1);
    assign bus.inv_e = stub_e;
    assign bus.inv_d = stub_d;

    // Compare process
    int          cyc = 0, acc_cyc = 0, n_start = 0, n_wait = 0;
    bit          pending = 0, inflight = 0;
    logic [63:0] pn = 0, pe = 0, pd = 0;
    logic        perr = 0, pvalid = 0;
    logic [23:0] pcyc = 0;
    exp_t        cur;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_req_ready", bus.req_ready, 1);
            chk("rst_key_valid", bus.key_valid, 0);
            chk("rst_inv_start", bus.inv_start, 0);
            chk("rst_key_n", bus.key_n, 0);
            chk("rst_key_err", bus.key_err, 0);
            pending = 0; inflight = 0;
            pn = 0; pe = 0; pd = 0; perr = 0; pcyc = 0; pvalid = 0;
        end else begin
            chk("busy", bus.busy, inflight);
            chk("req_ready", bus.req_ready, !inflight);
            if (pending && bus.inv_start) begin
                n_start++;
                if (expq.size() > 0) begin
                    chk("inv_p", bus.inv_p, expq[0].p);
                    chk("inv_q", bus.inv_q, expq[0].q);
                end
            end
            if (pending && bus.busy && !bus.inv_start && !bus.key_valid) n_wait++;
            if (bus.key_valid && !pvalid) begin
                if (!pending || expq.size() == 0) begin
                    chk("spurious_key_valid", bus.key_valid, 0);
                end else begin
                    cur = expq.pop_front();
                    chk("latency", 64'(cyc - acc_cyc), 64'(cur.bad ? 1 : 2 + cur.cycles));
                    chk("key_n", bus.key_n, cur.n);
                    chk("key_e", bus.key_e, cur.e);
                    chk("key_d", bus.key_d, cur.d);
                    chk("key_err", bus.key_err, cur.err);
                    chk("key_cycles", bus.key_cycles, 64'(cur.cycles));
                    chk("inv_start_pulses", 64'(n_start), cur.bad ? 0 : 1);
                    chk("wait_cycles", 64'(n_wait), 64'(cur.bad ? 0 : cur.cycles));
                    pending = 0;
                end
            end else begin
                chk("hold_key_n", bus.key_n, pn);
                chk("hold_key_e", bus.key_e, pe);
                chk("hold_key_d", bus.key_d, pd);
                chk("hold_key_err", bus.key_err, perr);
                chk("hold_key_cycles", bus.key_cycles, pcyc);
            end
            if (bus.req_valid && bus.req_ready) begin
                pending = 1; inflight = 1; acc_cyc = cyc; n_start = 0; n_wait = 0;
            end
            if (bus.key_valid && bus.key_ready) inflight = 0;
            pn = bus.key_n; pe = bus.key_e; pd = bus.key_d;
            perr = bus.key_err; pcyc = bus.key_cycles; pvalid = bus.key_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.req_ready && t < 100) begin step(); t++; end
        chk("ready_wait", bus.req_ready, 1);
    endtask

    task automatic issue(input logic [31:0] p, q, input logic [63:0] e, d,
                         input int dly, input bit never, stale, input exp_t x);
        wait_ready();
        stub_e = e; stub_d = d; stub_dly = dly; stub_never = never; stub_stale = stale;
        expq.push_back(x);
        bus.req_p = p; bus.req_q = q; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] p, q, input logic [63:0] e, d,
                        input int dly, input bit never, stale, input int hold, input exp_t x);
        int t = 0;
        issue(p, q, e, d, dly, never, stale, x);
        while (!bus.key_valid && t < 200) begin step(); t++; end
        chk("done_wait", bus.key_valid, 1);
        for (int i = 0; i < hold; i++) step();
        bus.key_ready = 1'b1;
        step();
        bus.key_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p, q;
        logic [63:0] e, d;
        int dly, sel, hold;
        bit nv, st;

        bus.req_valid = 0; bus.req_p = 0; bus.req_q = 0; bus.key_ready = 0;
        repeat (3) step();
        chk("init_busy", bus.busy, 0);
        chk("init_req_ready", bus.req_ready, 1);
        chk("init_inv_p", bus.inv_p, 0);
        chk("init_key_cycles", bus.key_cycles, 0);
        @(negedge clk);
        reset = 0;
        step();

        // Textbook key with a 10-cycle inverter.
        send(61, 53, 17, 2753, 10, 0, 0, 0, lit(61, 53, 3233, 17, 2753, 0, 10, 0));
        // Rejected operands.
        send(2, 53, 5, 7, 10, 0, 0, 0, lit(2, 53, 0, 0, 0, 1, 0, 1));
        send(61, 61, 5, 7, 10, 0, 0, 0, lit(61, 61, 0, 0, 0, 1, 0, 1));
        send(3, 5, 3, 3, 2, 0, 0, 0, lit(3, 5, 15, 3, 3, 0, 2, 0));
        // Inverter never finishes.
        send(61, 53, 17, 2753, 10, 1, 0, 0, lit(61, 53, 0, 0, 0, 1, 16, 0));
        // Stale finish across START and the first WAIT cycle.
        send(61, 53, 17, 2753, 10, 0, 1, 0, lit(61, 53, 3233, 17, 2753, 0, 10, 0));
        send(7, 11, 9, 13, 2, 0, 1, 0, lit(7, 11, 77, 9, 13, 0, 2, 0));
        // Finish coinciding with timeout, and one cycle too late.
        send(7, 11, 9, 13, 16, 0, 0, 0, lit(7, 11, 77, 9, 13, 0, 16, 0));
        send(7, 11, 9, 13, 17, 0, 0, 0, lit(7, 11, 0, 0, 0, 1, 16, 0));
        // Consumer stalls 20 cycles, then a back-to-back request.
        send(61, 53, 17, 2753, 4, 0, 0, 20, lit(61, 53, 3233, 17, 2753, 0, 4, 0));
        send(5, 3, 1, 2, 3, 0, 0, 0, lit(5, 3, 15, 1, 2, 0, 3, 0));

        for (int k = 0; k < 60; k++) begin
            p = $urandom; q = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) p = $urandom_range(0, 3);
            else if (sel == 1) q = $urandom_range(0, 3);
            else if (sel == 2) q = p;
            e = {$urandom, $urandom}; d = {$urandom, $urandom};
            dly = $urandom_range(2, 20);
            nv = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 3);
            send(p, q, e, d, dly, nv, st, hold, model(p, q, e, d, dly, nv));
        end

        // Asynchronous reset in the middle of WAIT.
        issue(61, 53, 17, 2753, 15, 0, 0, lit(61, 53, 3233, 17, 2753, 0, 15, 0));
        repeat (5) step();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_key_valid", bus.key_valid, 0);
        chk("async_rst_req_ready", bus.req_ready, 1);
        expq.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        step();
        send(61, 53, 17, 2753, 10, 0, 0, 0, lit(61, 53, 3233, 17, 2753, 0, 10, 0));

        repeat (5) step();
        chk("leftover_expectations", 64'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
